seg_digit_drawer: RTL and testbench

- Parametrised successor to the fixed per-digit line drawers: one block draws any decimal digit 0-9 as a seven-segment glyph.
- Emits one pixel per cycle (x, y, colour, plot strobe) to the VGA adapter path, offset from a caller-supplied tile origin.
- Uses a start/busy/done handshake so the game-state drawer can sequence tiles.
- Glyph size and in-tile offset are parameters, not hard-coded.

---
 rtl/seg_digit_pkg.sv | 50 +++++
 rtl/seg_line_stepper.sv | 68 ++++++
 rtl/seg_digit_drawer.sv | 176 +++++++++++++++++
 tb/tb_seg_digit_drawer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_digit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seg_digit_pkg
// Brief   : Shared types and tables for the seven-segment digit drawer:
//           FSM state encoding, segment indices, digit-to-mask decode and
//           segment orientation.
// Revision: 1.0 - initial release
// ============================================================================
package seg_digit_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DRAW = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Segment indices in drawing order a..g
  localparam logic [2:0] SEG_A = 3'd0;
  localparam logic [2:0] SEG_B = 3'd1;
  localparam logic [2:0] SEG_C = 3'd2;
  localparam logic [2:0] SEG_D = 3'd3;
  localparam logic [2:0] SEG_E = 3'd4;
  localparam logic [2:0] SEG_F = 3'd5;
  localparam logic [2:0] SEG_G = 3'd6;

  // Bit n set when segment n runs horizontally (a, d, g)
  localparam logic [6:0] SEG_HORIZ = 7'b1001001;

  // Lit segments for a decimal digit, bit order g..a; 10-15 are blank
  function automatic logic [6:0] digit_to_mask(input logic [3:0] d);
    logic [6:0] m;
    case (d)
      4'd0:    m = 7'b0111111;
      4'd1:    m = 7'b0000110;
      4'd2:    m = 7'b1011011;
      4'd3:    m = 7'b1001111;
      4'd4:    m = 7'b1100110;
      4'd5:    m = 7'b1101101;
      4'd6:    m = 7'b1111101;
      4'd7:    m = 7'b0000111;
      4'd8:    m = 7'b1111111;
      4'd9:    m = 7'b1101111;
      default: m = 7'b0000000;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_line_stepper.sv
`default_nettype none
// ============================================================================
// Module  : seg_line_stepper
// Brief   : Walks SEG_LEN pixels of one straight segment from a loaded start
//           point, horizontally or vertically, flagging the final pixel.
// Revision: 1.0 - initial release
// ============================================================================
module seg_line_stepper #(
  parameter int SEG_LEN = 7,
  parameter int X_W     = 8,
  parameter int Y_W     = 7
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           horiz_i,
  input  logic [X_W-1:0] x0_i,
  input  logic [Y_W-1:0] y0_i,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           last_o
);

  localparam logic [3:0] PIX_LAST = 4'(SEG_LEN - 1);

  logic [X_W-1:0] bx_q;
  logic [Y_W-1:0] by_q;
  logic           horiz_q;
  logic [3:0]     pix_q;
  logic [3:0]     pix_d;

  // Pixel index: restart on load, advance on step, park on the last pixel
  always_comb begin
    pix_d = pix_q;
    if (load_i) begin
      pix_d = 4'd0;
    end else if (step_i && !last_o) begin
      pix_d = pix_q + 4'd1;
    end
  end

  // Capture the segment start point and orientation, hold the pixel index
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bx_q    <= '0;
      by_q    <= '0;
      horiz_q <= 1'b0;
      pix_q   <= 4'd0;
    end else begin
      if (load_i) begin
        bx_q    <= x0_i;
        by_q    <= y0_i;
        horiz_q <= horiz_i;
      end
      pix_q <= pix_d;
    end
  end

  // Current coordinate: the index is added on the axis of travel only
  always_comb begin
    x_o    = horiz_q ? (bx_q + X_W'(pix_q)) : bx_q;
    y_o    = horiz_q ? by_q : (by_q + Y_W'(pix_q));
    last_o = (pix_q == PIX_LAST);
  end

endmodule
`default_nettype wire

// File: rtl/seg_digit_drawer.sv
`default_nettype none
// ============================================================================
// Module  : seg_digit_drawer
// Brief   : Draws a decimal digit as a seven-segment glyph, one pixel per
//           cycle, offset from a tile origin, with start/busy/done handshake.
// Revision: 1.0 - initial release
// ============================================================================
module seg_digit_drawer
  import seg_digit_pkg::*;
#(
  parameter int SEG_LEN = 7,
  parameter int X_OFF   = 11,
  parameter int Y_OFF   = 7,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int C_W     = 3
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           start,
  input  logic [3:0]     digit,
  input  logic [X_W-1:0] xIn,
  input  logic [Y_W-1:0] yIn,
  input  logic [C_W-1:0] colourIn,
  output logic           busy,
  output logic           done,
  output logic           plot,
  output logic [X_W-1:0] xOut,
  output logic [Y_W-1:0] yOut,
  output logic [C_W-1:0] colourOut
);

  localparam logic [X_W-1:0] L1_X = X_W'(SEG_LEN - 1);
  localparam logic [Y_W-1:0] L1_Y = Y_W'(SEG_LEN - 1);
  localparam logic [Y_W-1:0] L2_Y = Y_W'(2 * SEG_LEN - 2);

  state_e         state_q, state_d;
  logic [2:0]     seg_q, seg_d;
  logic [6:0]     mask_q;
  logic [X_W-1:0] ox_q;
  logic [Y_W-1:0] oy_q;
  logic [C_W-1:0] colour_q;

  logic           busy_q, done_q, plot_q;
  logic [X_W-1:0] xout_q;
  logic [Y_W-1:0] yout_q;
  logic [C_W-1:0] cout_q;

  logic           load;
  logic           step;
  logic [X_W-1:0] sx;
  logic [Y_W-1:0] sy;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic           last;

  // Next state: scan the mask one segment per cycle, draw lit segments
  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          seg_d   = SEG_A;
        end
      end
      S_SCAN: begin
        if (mask_q[seg_q]) begin
          load    = 1'b1;
          state_d = S_DRAW;
        end else if (seg_q == SEG_G) begin
          state_d = S_DONE;
        end else begin
          seg_d = seg_q + 3'd1;
        end
      end
      S_DRAW: begin
        step = 1'b1;
        if (last) begin
          if (seg_q == SEG_G) begin
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
            seg_d   = seg_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Start point of the segment currently being scanned
  always_comb begin
    sx = ox_q;
    sy = oy_q;
    case (seg_q)
      SEG_B:   begin sx = ox_q + L1_X; sy = oy_q;        end
      SEG_C:   begin sx = ox_q + L1_X; sy = oy_q + L1_Y; end
      SEG_D:   begin sx = ox_q;        sy = oy_q + L2_Y; end
      SEG_E:   begin sx = ox_q;        sy = oy_q + L1_Y; end
      SEG_G:   begin sx = ox_q;        sy = oy_q + L1_Y; end
      default: begin sx = ox_q;        sy = oy_q;        end
    endcase
  end

  seg_line_stepper #(
    .SEG_LEN (SEG_LEN),
    .X_W     (X_W),
    .Y_W     (Y_W)
  ) u_stepper (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (load),
    .step_i  (step),
    .horiz_i (SEG_HORIZ[seg_q]),
    .x0_i    (sx),
    .y0_i    (sy),
    .x_o     (px),
    .y_o     (py),
    .last_o  (last)
  );

  // State, segment index and the request snapshot taken at accept
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      seg_q    <= 3'd0;
      mask_q   <= 7'd0;
      ox_q     <= '0;
      oy_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      if (state_q == S_IDLE && start) begin
        mask_q   <= digit_to_mask(digit);
        ox_q     <= xIn + X_W'(X_OFF);
        oy_q     <= yIn + Y_W'(Y_OFF);
        colour_q <= colourIn;
      end
    end
  end

  // Registered outputs trail the state by one cycle; coordinates hold between pixels
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      plot_q <= 1'b0;
      xout_q <= '0;
      yout_q <= '0;
      cout_q <= '0;
    end else begin
      busy_q <= (state_q != S_IDLE);
      done_q <= (state_q == S_DONE);
      plot_q <= (state_q == S_DRAW);
      if (state_q == S_DRAW) begin
        xout_q <= px;
        yout_q <= py;
        cout_q <= colour_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plot      = plot_q;
  assign xOut      = xout_q;
  assign yOut      = yout_q;
  assign colourOut = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_digit_drawer.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_digit_drawer
// Brief   : Directed self-checking bench for seg_digit_drawer (L=7 and L=3).
// Revision: 1.0 - initial release
// ============================================================================
module tb_seg_digit_drawer;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       start3 = 1'b0;
  logic [3:0] digit = 4'd0;
  logic [7:0] xIn = 8'd0;
  logic [6:0] yIn = 7'd0;
  logic [2:0] colourIn = 3'd0;

  logic       busy, done, plot;
  logic [7:0] xOut;
  logic [6:0] yOut;
  logic [2:0] colourOut;

  logic       busy3, done3, plot3;
  logic [7:0] xOut3;
  logic [6:0] yOut3;
  logic [2:0] colourOut3;

  int n_checks = 0;
  int n_pass   = 0;

  int px [0:127];
  int py [0:127];
  int pc [0:127];

  always #5 clk = ~clk;

  seg_digit_drawer #(.SEG_LEN(7)) dut (
    .clk(clk), .resetn(resetn), .start(start), .digit(digit),
    .xIn(xIn), .yIn(yIn), .colourIn(colourIn),
    .busy(busy), .done(done), .plot(plot),
    .xOut(xOut), .yOut(yOut), .colourOut(colourOut)
  );

  seg_digit_drawer #(.SEG_LEN(3)) dut3 (
    .clk(clk), .resetn(resetn), .start(start3), .digit(digit),
    .xIn(xIn), .yIn(yIn), .colourIn(colourIn),
    .busy(busy3), .done(done3), .plot(plot3),
    .xOut(xOut3), .yOut(yOut3), .colourOut(colourOut3)
  );

  // Start one glyph on the L=7 instance and record every plotted pixel.
  // Cycle 0 is the accept edge; lat = -1 when done never arrives.
  // At poke_cyc (if >0) a one-cycle start with poke_d and a moved origin is injected.
  task automatic run_glyph(input logic [3:0] d, input logic [7:0] x, input logic [6:0] y,
                           input logic [2:0] c, input int poke_cyc, input logic [3:0] poke_d,
                           output int nplot, output int lat, output int nbusy);
    nplot = 0; lat = -1; nbusy = 0;
    @(negedge clk);
    digit = d; xIn = x; yIn = y; colourIn = c; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(posedge clk);
      #1;
      if (busy) nbusy++;
      if (plot) begin
        if (nplot < 128) begin
          px[nplot] = int'(xOut); py[nplot] = int'(yOut); pc[nplot] = int'(colourOut);
        end
        nplot++;
      end
      if (cyc == poke_cyc) begin
        start = 1'b1; digit = poke_d; xIn = x + 8'd40;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = cyc;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done, plot, xOut, yOut, colourOut} !== 21'd0)
      $display("FAIL reset_outputs got=%h want=0", {busy, done, plot, xOut, yOut, colourOut});
    else n_pass++;
    @(negedge clk) resetn = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, plot} !== 3'b000) $display("FAIL idle_after_reset got=%b want=000", {busy, done, plot});
    else n_pass++;
  endtask

  task automatic test_digit8();
    int np, lat, nb;
    run_glyph(4'd8, 8'd0, 7'd0, 3'd5, 0, 4'd0, np, lat, nb);
    n_checks++; if (np !== 49) $display("FAIL d8_plots got=%0d want=49", np); else n_pass++;
    n_checks++; if (lat !== 57) $display("FAIL d8_latency got=%0d want=57", lat); else n_pass++;
    n_checks++; if (nb !== 57) $display("FAIL d8_busy got=%0d want=57", nb); else n_pass++;
    n_checks++;
    if (px[0] !== 11 || py[0] !== 7 || pc[0] !== 5)
      $display("FAIL d8_first got=(%0d,%0d,c%0d) want=(11,7,c5)", px[0], py[0], pc[0]);
    else n_pass++;
    n_checks++;
    if (px[48] !== 17 || py[48] !== 13) $display("FAIL d8_last_g got=(%0d,%0d) want=(17,13)", px[48], py[48]);
    else n_pass++;
    // d: horizontal at y = 7+12 = 19, starts x = 11 (plot index 21)
    n_checks++;
    if (px[21] !== 11 || py[21] !== 19) $display("FAIL d8_d_start got=(%0d,%0d) want=(11,19)", px[21], py[21]);
    else n_pass++;
  endtask

  task automatic test_digit1();
    int np, lat, nb, bad;
    run_glyph(4'd1, 8'd20, 7'd10, 3'd2, 0, 4'd0, np, lat, nb);
    n_checks++; if (np !== 14) $display("FAIL d1_plots got=%0d want=14", np); else n_pass++;
    n_checks++; if (lat !== 22) $display("FAIL d1_latency got=%0d want=22", lat); else n_pass++;
    bad = 0;
    for (int i = 0; i < 14; i++) begin
      if (px[i] !== 37 || py[i] !== ((i < 7) ? (17 + i) : (16 + i))) bad++;
    end
    n_checks++; if (bad !== 0) $display("FAIL d1_bc_pixels got=%0d bad want=0", bad); else n_pass++;
  endtask

  task automatic test_blank();
    int np, lat, nb;
    run_glyph(4'd12, 8'd3, 7'd4, 3'd1, 0, 4'd0, np, lat, nb);
    n_checks++; if (np !== 0) $display("FAIL blank_plots got=%0d want=0", np); else n_pass++;
    n_checks++; if (lat !== 8) $display("FAIL blank_latency got=%0d want=8", lat); else n_pass++;
    n_checks++; if (nb !== 8) $display("FAIL blank_busy got=%0d want=8", nb); else n_pass++;
    @(posedge clk); #1;
    n_checks++; if ({busy, done} !== 2'b00) $display("FAIL blank_after got=%b want=00", {busy, done}); else n_pass++;
  endtask

  task automatic test_ignore_start();
    int np, lat, nb;
    run_glyph(4'd0, 8'd0, 7'd0, 3'd3, 12, 4'd5, np, lat, nb);
    n_checks++; if (np !== 42) $display("FAIL ign_plots got=%0d want=42", np); else n_pass++;
    n_checks++; if (lat !== 50) $display("FAIL ign_latency got=%0d want=50", lat); else n_pass++;
    n_checks++;
    if (px[7] !== 17 || py[7] !== 7) $display("FAIL ign_b_start got=(%0d,%0d) want=(17,7)", px[7], py[7]);
    else n_pass++;
    n_checks++;
    if (px[41] !== 11 || py[41] !== 13 || pc[41] !== 3)
      $display("FAIL ign_f_last got=(%0d,%0d,c%0d) want=(11,13,c3)", px[41], py[41], pc[41]);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0) $display("FAIL ign_no_restart got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    int np, lat, nb, dseen;
    @(negedge clk);
    digit = 4'd7; xIn = 8'd0; yIn = 7'd0; colourIn = 3'd6; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    n_checks++; if (plot !== 1'b1) $display("FAIL ar_in_draw got=%b want=1", plot); else n_pass++;
    #2 resetn = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, plot, xOut, yOut, colourOut} !== 21'd0)
      $display("FAIL ar_immediate got=%h want=0", {busy, done, plot, xOut, yOut, colourOut});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) resetn = 1'b1;
    dseen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || busy) dseen++;
    end
    n_checks++; if (dseen !== 0) $display("FAIL ar_no_done got=%0d want=0", dseen); else n_pass++;
    run_glyph(4'd7, 8'd0, 7'd0, 3'd6, 0, 4'd0, np, lat, nb);
    n_checks++; if (np !== 21) $display("FAIL ar_redraw_plots got=%0d want=21", np); else n_pass++;
    n_checks++; if (lat !== 29) $display("FAIL ar_redraw_latency got=%0d want=29", lat); else n_pass++;
  endtask

  task automatic test_wrap();
    int np, lat, nb;
    run_glyph(4'd8, 8'd250, 7'd0, 3'd7, 0, 4'd0, np, lat, nb);
    n_checks++; if (np !== 49) $display("FAIL wrap_plots got=%0d want=49", np); else n_pass++;
    n_checks++; if (px[0] !== 5 || py[0] !== 7) $display("FAIL wrap_a_start got=(%0d,%0d) want=(5,7)", px[0], py[0]); else n_pass++;
    n_checks++; if (px[7] !== 11) $display("FAIL wrap_b_x got=%0d want=11", px[7]); else n_pass++;
  endtask

  task automatic test_seglen3();
    int np, lat, fx, fy;
    np = 0; lat = -1; fx = -1; fy = -1;
    @(negedge clk);
    digit = 4'd8; xIn = 8'd0; yIn = 7'd0; start3 = 1'b1;
    @(posedge clk);
    #1 start3 = 1'b0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      @(posedge clk); #1;
      if (plot3) begin
        if (np == 20) begin fx = int'(xOut3); fy = int'(yOut3); end
        np++;
      end
      if (done3) begin lat = cyc; break; end
    end
    n_checks++; if (np !== 21) $display("FAIL l3_plots got=%0d want=21", np); else n_pass++;
    n_checks++; if (lat !== 29) $display("FAIL l3_latency got=%0d want=29", lat); else n_pass++;
    // g last pixel: (11+2, 7+2)
    n_checks++; if (fx !== 13 || fy !== 9) $display("FAIL l3_last_g got=(%0d,%0d) want=(13,9)", fx, fy); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int np, lat, nb, lat2, nbz;
    run_glyph(4'd12, 8'd0, 7'd0, 3'd1, 0, 4'd0, np, lat, nb);
    // done visible now, FSM already IDLE: this start is accepted next edge
    start = 1'b1; digit = 4'd15;
    @(posedge clk);
    #1 start = 1'b0;
    lat2 = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk); #1;
      if (done) begin lat2 = cyc; break; end
    end
    n_checks++; if (lat2 !== 8) $display("FAIL b2b_second_latency got=%0d want=8", lat2); else n_pass++;
    // start during the DONE state must be ignored
    @(negedge clk);
    digit = 4'd12; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_done_pulse got=%b want=1", done); else n_pass++;
    nbz = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy) nbz++;
    end
    n_checks++; if (nbz !== 0) $display("FAIL b2b_done_start_ignored got=%0d want=0", nbz); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_digit8();
    test_digit1();
    test_blank();
    test_ignore_start();
    test_async_reset();
    test_wrap();
    test_seglen3();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
